// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: opcode encodings, immediate formats, the decoded
// control bundle and the register-operand select helper.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    IMM_I    = 3'd0,
    IMM_S    = 3'd1,
    IMM_B    = 3'd2,
    IMM_U    = 3'd3,
    IMM_J    = 3'd4,
    IMM_NONE = 3'd5
  } imm_fmt_t;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic branch;
    logic jal;
    logic jalr;
    logic alu_src;
    logic illegal;
  } ctrl_t;

  // x0 reads as zero; a same-cycle write-back to the source wins over the
  // register file, which only sees the write after this edge.
  function automatic logic [31:0] sel_operand(
    input logic [4:0]  rs,
    input logic [31:0] rf,
    input logic        wb_en,
    input logic [4:0]  wb_rd,
    input logic [31:0] wb_data
  );
    if (rs == 5'd0) begin
      return 32'd0;
    end else if (wb_en && (wb_rd == rs)) begin
      return wb_data;
    end else begin
      return rf;
    end
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Immediate generator: builds the sign-extended 32-bit immediate for the
// given format. Purely combinational; shared with fetch branch prediction.
// Ports:
//   instr  in  [31:7] instruction word (opcode bits are not needed)
//   fmt    in  immediate format selector
//   imm    out 32-bit sign-extended immediate (0 for IMM_NONE)
module imm_gen
  import riscv_pkg::*;
(
  input  logic [31:7] instr,
  input  imm_fmt_t    fmt,
  output logic [31:0] imm
);

  // Format-dependent bit scatter and sign extension.
  always_comb begin
    imm = 32'd0;
    case (fmt)
      IMM_I:    imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:    imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:    imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:    imm = {instr[31:12], 12'd0};
      IMM_J:    imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      IMM_NONE: imm = 32'd0;
      default:  imm = 32'd0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: drives register-file read addresses, bypasses the
// same-cycle write-back, detects load-use hazards and registers operands,
// immediate and control bits into the ID/EX pipeline register.
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   in_valid/in_ready        fetch handshake; in_pc, in_instr payload
//   rf_rs1/rf_rs2            register-file read addresses (combinational)
//   rf_data1/rf_data2        register-file read data
//   wb_en/wb_rd/wb_data      write-back port, bypassed into operands
//   flush                    kill ID/EX and the incoming instruction
//   out_valid/out_ready      execute handshake
//   out_*                    registered ID/EX payload and control bits
module decode_stage
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [31:0]     in_instr,
  output logic [4:0]      rf_rs1,
  output logic [4:0]      rf_rs2,
  input  logic [XLEN-1:0] rf_data1,
  input  logic [XLEN-1:0] rf_data2,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_rs1_val,
  output logic [XLEN-1:0] out_rs2_val,
  output logic [XLEN-1:0] out_imm,
  output logic [4:0]      out_rd,
  output logic [2:0]      out_funct3,
  output logic            out_funct7b5,
  output logic            out_reg_write,
  output logic            out_mem_read,
  output logic            out_mem_write,
  output logic            out_branch,
  output logic            out_jal,
  output logic            out_jalr,
  output logic            out_alu_src,
  output logic            out_illegal
);

  ctrl_t       ctrl_s;
  imm_fmt_t    fmt_s;
  logic        use_rs1_s;
  logic        use_rs2_s;
  logic [31:0] imm_s;
  logic [31:0] rs1_val_s;
  logic [31:0] rs2_val_s;
  logic        stall_s;
  logic        ready_s;

  assign rf_rs1 = in_instr[19:15];
  assign rf_rs2 = in_instr[24:20];

  // Opcode decode: control bits, immediate format and which sources are read.
  always_comb begin
    ctrl_s    = ctrl_t'(8'h00);
    fmt_s     = IMM_NONE;
    use_rs1_s = 1'b0;
    use_rs2_s = 1'b0;
    case (in_instr[6:0])
      OP_R: begin
        ctrl_s.reg_write = 1'b1;
        use_rs1_s = 1'b1;
        use_rs2_s = 1'b1;
      end
      OP_IMM: begin
        ctrl_s.reg_write = 1'b1;
        ctrl_s.alu_src   = 1'b1;
        fmt_s     = IMM_I;
        use_rs1_s = 1'b1;
      end
      OP_LOAD: begin
        ctrl_s.reg_write = 1'b1;
        ctrl_s.mem_read  = 1'b1;
        ctrl_s.alu_src   = 1'b1;
        fmt_s     = IMM_I;
        use_rs1_s = 1'b1;
      end
      OP_STORE: begin
        ctrl_s.mem_write = 1'b1;
        ctrl_s.alu_src   = 1'b1;
        fmt_s     = IMM_S;
        use_rs1_s = 1'b1;
        use_rs2_s = 1'b1;
      end
      OP_BRANCH: begin
        ctrl_s.branch = 1'b1;
        fmt_s     = IMM_B;
        use_rs1_s = 1'b1;
        use_rs2_s = 1'b1;
      end
      OP_JAL: begin
        ctrl_s.reg_write = 1'b1;
        ctrl_s.jal       = 1'b1;
        fmt_s = IMM_J;
      end
      OP_JALR: begin
        ctrl_s.reg_write = 1'b1;
        ctrl_s.jalr      = 1'b1;
        ctrl_s.alu_src   = 1'b1;
        fmt_s     = IMM_I;
        use_rs1_s = 1'b1;
      end
      OP_LUI, OP_AUIPC: begin
        ctrl_s.reg_write = 1'b1;
        ctrl_s.alu_src   = 1'b1;
        fmt_s = IMM_U;
      end
      default: begin
        ctrl_s.illegal = 1'b1;
      end
    endcase
  end

  imm_gen u_imm_gen (
    .instr (in_instr[31:7]),
    .fmt   (fmt_s),
    .imm   (imm_s)
  );

  assign rs1_val_s = sel_operand(rf_rs1, rf_data1, wb_en, wb_rd, wb_data);
  assign rs2_val_s = sel_operand(rf_rs2, rf_data2, wb_en, wb_rd, wb_data);

  // A load in ID/EX whose result is needed now cannot be forwarded in time by
  // execute, so hold the consumer for one cycle. Unused source fields are
  // ignored so that e.g. an immediate field never fakes a dependency.
  assign stall_s = out_valid && out_mem_read && (out_rd != 5'd0) &&
                   ((use_rs1_s && (out_rd == rf_rs1)) ||
                    (use_rs2_s && (out_rd == rf_rs2)));

  // Flush consumes the incoming instruction unconditionally.
  assign ready_s  = rst && (flush || ((!out_valid || out_ready) && !stall_s));
  assign in_ready = ready_s;

  // ID/EX register: reset > flush > stall bubble > capture > hold.
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid     <= 1'b0;
      out_pc        <= 32'd0;
      out_rs1_val   <= 32'd0;
      out_rs2_val   <= 32'd0;
      out_imm       <= 32'd0;
      out_rd        <= 5'd0;
      out_funct3    <= 3'd0;
      out_funct7b5  <= 1'b0;
      out_reg_write <= 1'b0;
      out_mem_read  <= 1'b0;
      out_mem_write <= 1'b0;
      out_branch    <= 1'b0;
      out_jal       <= 1'b0;
      out_jalr      <= 1'b0;
      out_alu_src   <= 1'b0;
      out_illegal   <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (stall_s) begin
      if (out_ready) begin
        out_valid <= 1'b0;
      end
    end else if (in_valid && ready_s) begin
      out_valid     <= 1'b1;
      out_pc        <= in_pc;
      out_rs1_val   <= rs1_val_s;
      out_rs2_val   <= rs2_val_s;
      out_imm       <= imm_s;
      out_rd        <= ctrl_s.reg_write ? in_instr[11:7] : 5'd0;
      out_funct3    <= in_instr[14:12];
      out_funct7b5  <= in_instr[30];
      out_reg_write <= ctrl_s.reg_write;
      out_mem_read  <= ctrl_s.mem_read;
      out_mem_write <= ctrl_s.mem_write;
      out_branch    <= ctrl_s.branch;
      out_jal       <= ctrl_s.jal;
      out_jalr      <= ctrl_s.jalr;
      out_alu_src   <= ctrl_s.alu_src;
      out_illegal   <= ctrl_s.illegal;
    end else if (!out_valid || out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
